mem_copy_engine: RTL
====================

Name: mem_copy_engine

Overview:
- Bus-initiator block that drives the main-memory access port (rA, rB, rC, writeC; read data returned on dataB).
- Performs block copy (memory to memory) and block fill (constant to memory) over the main-memory region, addresses 0..MEM_DEPTH-1.
- Sits beside the core as a memory master. Software-style commands arrive on a start/done handshake.
- Write protocol of the memory port: the word driven on rA is stored at address rC at the posedge where writeC=1.

Parameters:
- MEM_DEPTH, 256, number of main-memory words; legal addresses are 0..MEM_DEPTH-1.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command request; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill.
- src  in  32  copy source base address; ignored in fill mode.
- dst  in  32  destination base address.
- len  in  32  word count.
- pattern  in  32  fill value.
- busy  out  1  high while a command is executing.
- done  out  1  one-cycle completion pulse.
- err  out  1  range error on the last command; held until the next accepted start.
- rA  out  32  memory port A; carries write data during write cycles.
- rB  out  32  memory read address.
- rC  out  32  memory write address.
- writeC  out  1  memory write enable.
- dataB  in  32  memory read data for rB; combinational, same cycle.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, err=0; rA=rB=rC=0; writeC=0. Internal counters and buffer cleared. Memory writes already performed are not undone.
- Outputs are Moore, decoded from registered state, cur_src, cur_dst and buf. In IDLE and DONE the bus is driven rA=rB=rC=0, writeC=0.
- States: IDLE, RD, WR, FILL, DONE.
- IDLE:
  - When start=1 at a posedge, latch mode, src, dst, len and pattern; clear err.
  - Range check uses 33-bit arithmetic: fail if len>MEM_DEPTH, or dst>MEM_DEPTH-len, or (mode=0 and src>MEM_DEPTH-len).
  - Fail: err=1, next state DONE, no memory access.
  - len=0: next state DONE, err=0, no access.
  - Otherwise: next state RD (copy) or FILL (fill).
- RD:
  - Drive rB=cur_src, writeC=0.
  - At posedge: buf<=dataB, next state WR.
- WR:
  - Drive rA=buf, rC=cur_dst, writeC=1.
  - At posedge: cur_src+1, cur_dst+1, count-1.
  - If count reaches 0, next state DONE; else next state RD.
- FILL:
  - Drive rA=pattern, rC=cur_dst, writeC=1.
  - At posedge: cur_dst+1, count-1.
  - If count reaches 0, next state DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- busy=1 in RD, WR and FILL only.
- start is ignored in every state except IDLE. It is not queued.
- Latency, with start sampled at edge 0:
  - Copy of N words: busy for 2N cycles, done high in cycle 2N+1.
  - Fill: busy for N cycles, done in cycle N+1.
  - Error or len=0: done in cycle 1.
- Overlapping ranges: strictly sequential forward element copy. Word i is read only after word i-1 has been written. Therefore dst=src+1 replicates mem[src] across the range; dst<src gives a correct memmove.
- Addresses never exceed MEM_DEPTH-1 during execution. Peripheral space at MEM_DEPTH and above is never touched.
- Command inputs may change freely once start has been accepted.

Test Plan:
- Fill: mode=1, dst=10, len=4, pattern=0xDEADBEEF. Required: mem[10..13]=0xDEADBEEF; writeC high on cycles 1..4; done in cycle 5; mem[9] and mem[14] unchanged.
- Copy: preload mem[0..2]=0x11,0x22,0x33; mode=0, src=0, dst=100, len=3. Required: mem[100..102]=0x11,0x22,0x33; RD/WR alternate; done in cycle 7; err=0.
- Overlap smear: mem[20..23]=1,2,3,4; copy src=20, dst=21, len=3. Required: mem[20..23]=1,1,1,1.
- Range/empty:
  - Copy src=250, dst=0, len=10. Required: err=1, done in cycle 1, writeC never asserted, no memory change.
  - len=0. Required: done in cycle 1, err=0.
  - Fill dst=256, len=1. Required: err=1.
- Busy/ignore: during a len=8 fill, pulse start with a different command. Required: ignored; the original fill completes; exactly one done pulse.
- Reset mid-op: assert rst asynchronously mid-edge during a len=8 fill after 3 writes. Required: outputs immediately 0 and IDLE; mem[dst..dst+2] written, rest unchanged; a new command after reset runs normally.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Memory-master block-copy / block-fill engine driving the main-memory port.
// Commands arrive on a start/done handshake and are range-checked before any bus access.
module mem_copy_engine #(
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [31:0] src,
  input  logic [31:0] dst,
  input  logic [31:0] len,
  input  logic [31:0] pattern,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rA,
  output logic [31:0] rB,
  output logic [31:0] rC,
  output logic        writeC,
  input  logic [31:0] dataB
);

  localparam logic [32:0] DEPTH33 = 33'(MEM_DEPTH);

  typedef enum logic [2:0] {IDLE, RD, WR, FILL, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] cur_src, cur_dst, count, data_buf, pattern_q;
  logic        range_fail;

  // 33-bit compare keeps base+len overflow from wrapping into a false pass
  always_comb begin
    range_fail = 1'b0;
    if ({1'b0, len} > DEPTH33)
      range_fail = 1'b1;
    else if ({1'b0, dst} > DEPTH33 - {1'b0, len})
      range_fail = 1'b1;
    else if (!mode && ({1'b0, src} > DEPTH33 - {1'b0, len}))
      range_fail = 1'b1;
  end

  // State register and datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_src   <= '0;
      cur_dst   <= '0;
      count     <= '0;
      data_buf  <= '0;
      pattern_q <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            cur_src   <= src;
            cur_dst   <= dst;
            count     <= len;
            pattern_q <= pattern;
            err       <= range_fail;
          end
        end
        RD: data_buf <= dataB;
        WR: begin
          cur_src <= cur_src + 32'd1;
          cur_dst <= cur_dst + 32'd1;
          count   <= count - 32'd1;
        end
        FILL: begin
          cur_dst <= cur_dst + 32'd1;
          count   <= count - 32'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state and Moore bus decode
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    rA         = '0;
    rB         = '0;
    rC         = '0;
    writeC     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (range_fail || (len == 32'd0)) state_next = DONE;
          else if (mode)                    state_next = FILL;
          else                              state_next = RD;
        end
      end
      RD: begin
        busy       = 1'b1;
        rB         = cur_src;
        state_next = WR;
      end
      WR: begin
        busy       = 1'b1;
        rA         = data_buf;
        rC         = cur_dst;
        writeC     = 1'b1;
        state_next = (count == 32'd1) ? DONE : RD;
      end
      FILL: begin
        busy   = 1'b1;
        rA     = pattern_q;
        rC     = cur_dst;
        writeC = 1'b1;
        if (count == 32'd1) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
